updown_mod_counter: RTL and testbench

Parametrised, loadable up/down counter with a runtime modulus, a programmable step, and selectable wrap or saturate behaviour. It is the general-purpose sequencing and timing counter for the catalog. Typical uses are address generators, baud and tick dividers, and loop counters in datapaths. When disabled it holds its value and never drives Z, so it sits directly on internal buses and feeds downstream logic without qualification.

---
 rtl/updown_mod_counter_if.sv | 28 ++
 rtl/updown_mod_counter.sv | 126 ++++++++++++
 tb/tb_updown_mod_counter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// Control/data bundle for updown_mod_counter: the master drives controls and
// the modulus, the counter (slave) returns the count and its status flags.
interface updown_mod_counter_if #(
  parameter int N      = 8,
  parameter int STEP_W = 4
) ();
  logic              clr;
  logic              load;
  logic [N-1:0]      d;
  logic              en;
  logic              up_down;
  logic [STEP_W-1:0] step;
  logic [N-1:0]      lim;
  logic [N-1:0]      q;
  logic              tc;
  logic              wrap;
  logic              ovf;

  modport master (
    output clr, load, d, en, up_down, step, lim,
    input  q, tc, wrap, ovf
  );

  modport slave (
    input  clr, load, d, en, up_down, step, lim,
    output q, tc, wrap, ovf
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Loadable up/down counter over the range 0..lim with a programmable step,
// wrap or saturate at the boundary, one-cycle wrap pulse and sticky ovf.
module updown_mod_counter #(
  parameter int N        = 8,
  parameter int STEP_W   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  updown_mod_counter_if.slave bus
);

  logic [N-1:0]      r_q;
  logic              r_wrap;
  logic              r_ovf;

  logic [STEP_W-1:0] w_step_eff;
  logic [N:0]        w_q_ext;
  logic [N:0]        w_lim_ext;
  logic [N:0]        w_mod;
  logic [N:0]        w_s;
  logic [N:0]        w_s_mod;
  logic [N:0]        w_up_sum;
  logic              w_up_over;
  logic [N:0]        w_up_raw;
  logic [N:0]        w_up_wrap;
  logic              w_dn_under;
  logic [N:0]        w_dn_diff;
  logic [N:0]        w_dn_raw;
  logic [N:0]        w_dn_wrap;
  logic [N:0]        w_next_ext;
  logic [N-1:0]      w_next;
  logic              w_event;
  logic [N-1:0]      w_load_val;
  logic              w_unused_msb;

  // All arithmetic is one bit wider than q so sums and lim+1 never truncate.
  assign w_step_eff = (bus.step == '0) ? STEP_W'(1) : bus.step;
  assign w_q_ext    = {1'b0, r_q};
  assign w_lim_ext  = {1'b0, bus.lim};
  assign w_mod      = w_lim_ext + 1'b1;
  assign w_s        = (N+1)'(w_step_eff);

  // Restoring remainder s mod (lim+1), one compare-subtract per step bit.
  always_comb begin
    w_s_mod = '0;
    for (int i = STEP_W - 1; i >= 0; i--) begin
      w_s_mod = {w_s_mod[N-1:0], w_step_eff[i]};
      if (w_s_mod >= w_mod) begin
        w_s_mod = w_s_mod - w_mod;
      end
    end
  end

  assign w_up_sum   = w_q_ext + w_s;
  assign w_up_over  = (w_up_sum > w_lim_ext);
  assign w_up_raw   = w_q_ext + w_s_mod;
  assign w_up_wrap  = (w_up_raw >= w_mod) ? (w_up_raw - w_mod) : w_up_raw;

  assign w_dn_under = (w_q_ext < w_s);
  assign w_dn_diff  = w_q_ext - w_s;
  assign w_dn_raw   = w_q_ext + w_mod - w_s_mod;
  assign w_dn_wrap  = (w_dn_raw >= w_mod) ? (w_dn_raw - w_mod) : w_dn_raw;

  // q above lim only happens after lim is lowered at runtime; recover to 0.
  always_comb begin
    w_next_ext = '0;
    w_event    = 1'b0;
    if (w_q_ext > w_lim_ext) begin
      w_next_ext = '0;
      w_event    = 1'b1;
    end else if (bus.up_down) begin
      w_event = w_up_over;
      if (!w_up_over) begin
        w_next_ext = w_up_sum;
      end else if (SATURATE) begin
        w_next_ext = w_lim_ext;
      end else begin
        w_next_ext = w_up_wrap;
      end
    end else begin
      w_event = w_dn_under;
      if (!w_dn_under) begin
        w_next_ext = w_dn_diff;
      end else if (SATURATE) begin
        w_next_ext = '0;
      end else begin
        w_next_ext = w_dn_wrap;
      end
    end
  end

  assign w_next       = w_next_ext[N-1:0];
  assign w_unused_msb = w_next_ext[N];
  assign w_load_val   = (bus.d > bus.lim) ? bus.lim : bus.d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.clr) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.load) begin
      r_q    <= w_load_val;
      r_wrap <= 1'b0;
    end else if (bus.en) begin
      r_q    <= w_next;
      r_wrap <= w_event;
      if (w_event) begin
        r_ovf <= 1'b1;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.q    = r_q;
  assign bus.wrap = r_wrap;
  assign bus.ovf  = r_ovf;
  assign bus.tc   = bus.en & ((bus.up_down & (r_q >= bus.lim)) |
                              (~bus.up_down & (r_q == '0)));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: one wrap-mode and one saturate-mode
// instance, sharing clock and reset, checked against hand-computed tables.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  updown_mod_counter_if #(.N(8), .STEP_W(4)) if_w ();
  updown_mod_counter_if #(.N(8), .STEP_W(4)) if_s ();

  updown_mod_counter #(.N(8), .STEP_W(4), .SATURATE(1'b0)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (if_w)
  );

  updown_mod_counter #(.N(8), .STEP_W(4), .SATURATE(1'b1)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (if_s)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic init_inputs();
    if_w.clr = 0; if_w.load = 0; if_w.d = 0; if_w.en = 0;
    if_w.up_down = 1; if_w.step = 1; if_w.lim = 8'd255;
    if_s.clr = 0; if_s.load = 0; if_s.d = 0; if_s.en = 0;
    if_s.up_down = 1; if_s.step = 1; if_s.lim = 8'd255;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    total++;
    if ({if_w.q, if_w.wrap, if_w.ovf} !== 10'h000) begin
      bad++; $display("FAIL reset_init_wrap: got q=%0d wrap=%b ovf=%b want 0/0/0", if_w.q, if_w.wrap, if_w.ovf);
    end
    total++;
    if ({if_s.q, if_s.wrap, if_s.ovf} !== 10'h000) begin
      bad++; $display("FAIL reset_init_sat: got q=%0d wrap=%b ovf=%b want 0/0/0", if_s.q, if_s.wrap, if_s.ovf);
    end
    @(negedge clk);
    rst = 1'b1;
    // 0x30 + 7 = 0x37 overruns lim 0x31: (55 mod 50) = 5, sets ovf
    if_w.lim = 8'h31; if_w.d = 8'h30; if_w.load = 1;
    tick();
    if_w.load = 0; if_w.en = 1; if_w.up_down = 1; if_w.step = 4'd7;
    tick();
    if_w.en = 0;
    total++;
    if (if_w.q !== 8'd5 || if_w.wrap !== 1'b1 || if_w.ovf !== 1'b1) begin
      bad++; $display("FAIL reset_prewrap: got q=%0d wrap=%b ovf=%b want 5/1/1", if_w.q, if_w.wrap, if_w.ovf);
    end
    if_w.lim = 8'd255; if_w.d = 8'h30; if_w.load = 1;
    tick();
    if_w.load = 0; if_w.en = 1;
    tick();
    if_w.en = 0;
    total++;
    if (if_w.q !== 8'h37 || if_w.wrap !== 1'b0 || if_w.ovf !== 1'b1) begin
      bad++; $display("FAIL reset_reach37: got q=%0d wrap=%b ovf=%b want 55/0/1", if_w.q, if_w.wrap, if_w.ovf);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if (if_w.q !== 8'd0 || if_w.wrap !== 1'b0 || if_w.ovf !== 1'b0) begin
      bad++; $display("FAIL reset_async: got q=%0d wrap=%b ovf=%b want 0/0/0", if_w.q, if_w.wrap, if_w.ovf);
    end
    if_w.en = 1;
    @(negedge clk);
    total++;
    if (if_w.q !== 8'd0) begin
      bad++; $display("FAIL reset_hold_low: got q=%0d want 0", if_w.q);
    end
    rst = 1'b1;
    tick();
    if_w.en = 0;
    total++;
    if (if_w.q !== 8'd7 || if_w.wrap !== 1'b0) begin
      bad++; $display("FAIL reset_restart: got q=%0d wrap=%b want 7/0", if_w.q, if_w.wrap);
    end
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_q   [0:4];
    logic       exp_w   [0:4];
    logic       exp_o   [0:4];
    logic       exp_tc  [0:4];
    exp_q  = '{8'd3, 8'd6, 8'd9, 8'd2, 8'd5};
    exp_w  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_o  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    if_w.clr = 1;
    tick();
    if_w.clr = 0;
    if_w.lim = 8'd9; if_w.step = 4'd3; if_w.up_down = 1; if_w.en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (if_w.q !== exp_q[i] || if_w.wrap !== exp_w[i] || if_w.ovf !== exp_o[i] || if_w.tc !== exp_tc[i]) begin
        bad++;
        $display("FAIL up_wrap[%0d]: got q=%0d wrap=%b ovf=%b tc=%b want %0d/%b/%b/%b",
                 i, if_w.q, if_w.wrap, if_w.ovf, if_w.tc, exp_q[i], exp_w[i], exp_o[i], exp_tc[i]);
      end
    end
    if_w.en = 0;
  endtask

  task automatic test_multi_lap();
    logic [7:0] exp_q [0:2];
    exp_q = '{8'd2, 8'd4, 8'd2};
    if_w.clr = 1;
    tick();
    if_w.clr = 0;
    // modulus 5, step 12: 0->2->4 going up, 4->2 going down
    if_w.lim = 8'd4; if_w.step = 4'd12; if_w.up_down = 1; if_w.en = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) if_w.up_down = 0;
      tick();
      total++;
      if (if_w.q !== exp_q[i] || if_w.wrap !== 1'b1 || if_w.ovf !== 1'b1) begin
        bad++;
        $display("FAIL multi_lap[%0d]: got q=%0d wrap=%b ovf=%b want %0d/1/1", i, if_w.q, if_w.wrap, if_w.ovf, exp_q[i]);
      end
    end
    if_w.en = 0; if_w.up_down = 1;
  endtask

  task automatic test_load_clamp();
    if_w.lim = 8'd50; if_w.d = 8'd100; if_w.load = 1; if_w.en = 1; if_w.step = 1; if_w.up_down = 1;
    tick();
    total++;
    if (if_w.q !== 8'd50 || if_w.wrap !== 1'b0 || if_w.ovf !== 1'b1) begin
      bad++; $display("FAIL load_clamp: got q=%0d wrap=%b ovf=%b want 50/0/1", if_w.q, if_w.wrap, if_w.ovf);
    end
    if_w.clr = 1; if_w.load = 1; if_w.d = 8'd10;
    tick();
    total++;
    if (if_w.q !== 8'd0 || if_w.ovf !== 1'b0 || if_w.wrap !== 1'b0) begin
      bad++; $display("FAIL clr_load: got q=%0d ovf=%b wrap=%b want 0/0/0", if_w.q, if_w.ovf, if_w.wrap);
    end
    if_w.clr = 0; if_w.load = 1; if_w.d = 8'd50; if_w.en = 0;
    tick();
    if_w.load = 0; if_w.en = 1;
    tick();
    total++;
    if (if_w.q !== 8'd0 || if_w.wrap !== 1'b1 || if_w.ovf !== 1'b1) begin
      bad++; $display("FAIL lim_wrap: got q=%0d wrap=%b ovf=%b want 0/1/1", if_w.q, if_w.wrap, if_w.ovf);
    end
    if_w.en = 0; if_w.load = 1;
    tick();
    if_w.load = 0; if_w.clr = 1; if_w.en = 1;
    tick();
    if_w.clr = 0; if_w.en = 0;
    total++;
    if (if_w.q !== 8'd0 || if_w.wrap !== 1'b0 || if_w.ovf !== 1'b0) begin
      bad++; $display("FAIL clr_en: got q=%0d wrap=%b ovf=%b want 0/0/0", if_w.q, if_w.wrap, if_w.ovf);
    end
  endtask

  task automatic test_down_sat();
    logic [7:0] exp_q [0:3];
    logic       exp_w [0:3];
    exp_q = '{8'd3, 8'd1, 8'd0, 8'd0};
    exp_w = '{1'b0, 1'b0, 1'b1, 1'b1};
    if_s.lim = 8'd200; if_s.d = 8'd5; if_s.load = 1;
    tick();
    if_s.load = 0; if_s.en = 1; if_s.step = 4'd2; if_s.up_down = 0;
    #1;
    total++;
    if (if_s.q !== 8'd5 || if_s.tc !== 1'b0) begin
      bad++; $display("FAIL sat_load: got q=%0d tc=%b want 5/0", if_s.q, if_s.tc);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (if_s.q !== exp_q[i] || if_s.wrap !== exp_w[i] || if_s.ovf !== exp_w[i] || if_s.tc !== exp_w[i]) begin
        bad++;
        $display("FAIL down_sat[%0d]: got q=%0d wrap=%b ovf=%b tc=%b want %0d/%b/%b/%b",
                 i, if_s.q, if_s.wrap, if_s.ovf, if_s.tc, exp_q[i], exp_w[i], exp_w[i], exp_w[i]);
      end
    end
    if_s.load = 1; if_s.d = 8'd198; if_s.up_down = 1; if_s.step = 4'd3;
    tick();
    if_s.load = 0;
    total++;
    if (if_s.q !== 8'd198 || if_s.wrap !== 1'b0) begin
      bad++; $display("FAIL sat_load198: got q=%0d wrap=%b want 198/0", if_s.q, if_s.wrap);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (if_s.q !== 8'd200 || if_s.wrap !== 1'b1 || if_s.tc !== 1'b1) begin
        bad++; $display("FAIL up_sat[%0d]: got q=%0d wrap=%b tc=%b want 200/1/1", i, if_s.q, if_s.wrap, if_s.tc);
      end
    end
    if_s.en = 0;
  endtask

  task automatic test_runtime_lim();
    if_w.lim = 8'd255; if_w.d = 8'd200; if_w.load = 1;
    tick();
    if_w.load = 0; if_w.lim = 8'd100; if_w.step = 4'd1; if_w.up_down = 1; if_w.en = 1;
    tick();
    total++;
    if (if_w.q !== 8'd0 || if_w.wrap !== 1'b1 || if_w.ovf !== 1'b1) begin
      bad++; $display("FAIL lim_lowered: got q=%0d wrap=%b ovf=%b want 0/1/1", if_w.q, if_w.wrap, if_w.ovf);
    end
    if_w.step = 4'd0;
    tick();
    total++;
    if (if_w.q !== 8'd1 || if_w.wrap !== 1'b0) begin
      bad++; $display("FAIL step_zero_a: got q=%0d wrap=%b want 1/0", if_w.q, if_w.wrap);
    end
    tick();
    total++;
    if (if_w.q !== 8'd2) begin
      bad++; $display("FAIL step_zero_b: got q=%0d want 2", if_w.q);
    end
    if_w.en = 0; if_w.step = 4'd1;
  endtask

  task automatic test_lim_zero();
    if_w.clr = 1;
    tick();
    if_w.clr = 0; if_w.lim = 8'd0; if_w.step = 4'd5; if_w.up_down = 1; if_w.en = 1;
    #1;
    total++;
    if (if_w.tc !== 1'b1) begin
      bad++; $display("FAIL lim0_tc: got tc=%b want 1", if_w.tc);
    end
    tick();
    total++;
    if (if_w.q !== 8'd0 || if_w.wrap !== 1'b1 || if_w.ovf !== 1'b1) begin
      bad++; $display("FAIL lim0_up: got q=%0d wrap=%b ovf=%b want 0/1/1", if_w.q, if_w.wrap, if_w.ovf);
    end
    if_w.up_down = 0;
    tick();
    total++;
    if (if_w.q !== 8'd0 || if_w.wrap !== 1'b1) begin
      bad++; $display("FAIL lim0_down: got q=%0d wrap=%b want 0/1", if_w.q, if_w.wrap);
    end
    if_w.en = 0;
  endtask

  task automatic test_hold();
    logic [7:0] lim_v;
    if_w.lim = 8'd100; if_w.d = 8'd20; if_w.load = 1;
    tick();
    if_w.load = 0; if_w.en = 0;
    for (int i = 0; i < 10; i++) begin
      lim_v = 8'(i * 7 + 3);
      if_w.up_down = i[0];
      if_w.step = 4'(i);
      if_w.lim = lim_v;
      tick();
      total++;
      if (if_w.q !== 8'd20 || if_w.wrap !== 1'b0 || if_w.tc !== 1'b0 || if_w.ovf !== 1'b1) begin
        bad++;
        $display("FAIL hold[%0d]: got q=%0d wrap=%b tc=%b ovf=%b want 20/0/0/1", i, if_w.q, if_w.wrap, if_w.tc, if_w.ovf);
      end
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_up_wrap();
    test_multi_lap();
    test_load_clamp();
    test_down_sat();
    test_runtime_lim();
    test_lim_zero();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
